// File: rtl/racket_ctrl.sv
// racket_ctrl: Pong paddle controller with configurable geometry, a
// movement-rate prescaler, hold-to-accelerate stepping and an auto
// (CPU-player) mode that tracks the ball's vertical position.
//
// last_dir acts as the controller's small state register:
//   state     | meaning
//   DIR_IDLE  | no movement on the previous tick (or just reset)
//   DIR_UP    | previous tick moved (or pushed) toward y=0
//   DIR_DOWN  | previous tick moved (or pushed) toward larger y
module racket_ctrl #(
    parameter int Y_W         = 10,
    parameter int SCREEN_H    = 480,
    parameter int RACKET_H    = 80,
    parameter int MOVE_DIV    = 100000,
    parameter int STEP_MIN    = 1,
    parameter int STEP_MAX    = 8,
    parameter int ACCEL_TICKS = 4,
    parameter int AUTO_STEP   = 2,
    parameter int DEADZONE    = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           enable,
    input  logic           mode_auto,
    input  logic           up,
    input  logic           down,
    input  logic [Y_W-1:0] ball_y,
    output logic [Y_W-1:0] racket_y,
    output logic           moving,
    output logic           at_top,
    output logic           at_bottom
);

    localparam int Y_MAX_I = SCREEN_H - RACKET_H;
    localparam int DIV_W   = $clog2(MOVE_DIV);
    localparam int HOLD_W  = $clog2(ACCEL_TICKS + 1);

    localparam logic [Y_W-1:0]   Y_MAX    = Y_MAX_I[Y_W-1:0];
    localparam logic [Y_W-1:0]   Y_RST    = Y_W'(Y_MAX_I / 2);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(MOVE_DIV - 1);
    localparam logic [Y_W-1:0]   S_MIN    = Y_W'(STEP_MIN);
    localparam logic [Y_W-1:0]   S_MAX    = Y_W'(STEP_MAX);
    localparam logic [Y_W-1:0]   S_AUTO   = Y_W'(AUTO_STEP);

    localparam logic [1:0] DIR_IDLE = 2'd0;
    localparam logic [1:0] DIR_UP   = 2'd1;
    localparam logic [1:0] DIR_DOWN = 2'd2;

    logic [DIV_W-1:0]  div_cnt;
    logic [Y_W-1:0]    step;
    logic [HOLD_W-1:0] hold;
    logic [1:0]        last_dir;

    logic              tick;
    logic [1:0]        dir_man;
    logic [1:0]        dir_auto;
    logic [1:0]        dir;
    logic              same_dir;
    logic [Y_W-1:0]    cur;
    logic [HOLD_W-1:0] hold_n;
    logic [Y_W-1:0]    step_inc;
    logic [Y_W:0]      y_ext;
    logic [Y_W:0]      cur_ext;
    logic [Y_W:0]      centre;
    logic [Y_W:0]      ball_ext;
    logic [Y_W:0]      dead_ext;
    logic [Y_W-1:0]    y_next;

    assign tick = (div_cnt == DIV_LAST);

    // Direction request: manual buttons or ball tracking, frozen when disabled.
    always_comb begin
        y_ext    = {1'b0, racket_y};
        ball_ext = {1'b0, ball_y};
        dead_ext = (Y_W+1)'(DEADZONE);
        centre   = y_ext + (Y_W+1)'(RACKET_H / 2);

        dir_man = DIR_IDLE;
        if (up && !down)
            dir_man = DIR_UP;
        else if (down && !up)
            dir_man = DIR_DOWN;

        dir_auto = DIR_IDLE;
        if (ball_ext + dead_ext < centre)
            dir_auto = DIR_UP;
        else if (ball_ext > centre + dead_ext)
            dir_auto = DIR_DOWN;

        if (!enable)
            dir = DIR_IDLE;
        else if (mode_auto)
            dir = dir_auto;
        else
            dir = dir_man;
    end

    // Step size for this tick, acceleration bookkeeping and clamped new position.
    always_comb begin
        same_dir = (dir == last_dir);

        if (mode_auto)
            cur = S_AUTO;
        else if (same_dir)
            cur = step;
        else
            cur = S_MIN;

        hold_n = same_dir ? hold + HOLD_W'(1) : HOLD_W'(1);

        step_inc = (({1'b0, cur} + (Y_W+1)'(1)) > {1'b0, S_MAX}) ? S_MAX : cur + Y_W'(1);

        cur_ext = {1'b0, cur};
        y_next  = racket_y;
        if (dir == DIR_UP)
            y_next = (y_ext < cur_ext) ? '0 : racket_y - cur;
        else if (dir == DIR_DOWN)
            y_next = ((y_ext + cur_ext) > {1'b0, Y_MAX}) ? Y_MAX : racket_y + cur;
    end

    // Prescaler and per-tick position/acceleration update.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt  <= '0;
            racket_y <= Y_RST;
            moving   <= 1'b0;
            step     <= S_MIN;
            hold     <= '0;
            last_dir <= DIR_IDLE;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
            if (tick) begin
                if (dir == DIR_IDLE) begin
                    moving   <= 1'b0;
                    step     <= S_MIN;
                    hold     <= '0;
                    last_dir <= DIR_IDLE;
                end else begin
                    racket_y <= y_next;
                    moving   <= (y_next != racket_y);
                    last_dir <= dir;
                    if (mode_auto) begin
                        step <= S_MIN;
                        hold <= '0;
                    end else if (hold_n == HOLD_W'(ACCEL_TICKS)) begin
                        step <= step_inc;
                        hold <= '0;
                    end else begin
                        step <= cur;
                        hold <= hold_n;
                    end
                end
            end
        end
    end

    assign at_top    = (racket_y == '0);
    assign at_bottom = (racket_y == Y_MAX);

endmodule

// File: tb/tb_racket_ctrl.sv
// tb_racket_ctrl: scoreboard bench for racket_ctrl with a short prescaler.
// Stimulus pushes the expected post-tick state; a monitor pops and compares
// one cycle after every movement tick.
module tb_racket_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       mode_auto;
    logic       up;
    logic       down;
    logic [9:0] ball_y;
    logic [9:0] racket_y;
    logic       moving;
    logic       at_top;
    logic       at_bottom;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int    y;
        int    mv;
        string nm;
    } exp_t;

    exp_t exp_q[$];

    racket_ctrl #(
        .MOVE_DIV   (4),
        .ACCEL_TICKS(2),
        .STEP_MAX   (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .mode_auto(mode_auto),
        .up       (up),
        .down     (down),
        .ball_y   (ball_y),
        .racket_y (racket_y),
        .moving   (moving),
        .at_top   (at_top),
        .at_bottom(at_bottom)
    );

    always #5 clk = ~clk;

    // Bench-side tick timing: 4-cycle prescaler restarting at reset.
    int   tb_cnt = 0;
    logic tick_d = 1'b0;
    always @(posedge clk) begin
        if (reset) begin
            tb_cnt <= 0;
            tick_d <= 1'b0;
        end else begin
            tb_cnt <= (tb_cnt == 3) ? 0 : tb_cnt + 1;
            tick_d <= (tb_cnt == 3);
        end
    end

    task automatic chk(input string nm, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, expv);
        end
    endtask

    // Monitor: after each tick the DUT presents a new position.
    always @(negedge clk) begin
        if (tick_d && exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk({e.nm, "_y"}, int'(racket_y), e.y);
            chk({e.nm, "_moving"}, int'(moving), e.mv);
            chk({e.nm, "_at_top"}, int'(at_top), (e.y == 0) ? 1 : 0);
            chk({e.nm, "_at_bottom"}, int'(at_bottom), (e.y == 400) ? 1 : 0);
        end
    end

    task automatic run_tick(input int ey, input int em, input string nm);
        int n;
        exp_t e;
        e.y  = ey;
        e.mv = em;
        e.nm = nm;
        exp_q.push_back(e);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tick_d && n < 8);
        if (!tick_d) chk({nm, "_tick_timeout"}, 0, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("reset_y", int'(racket_y), 200);
        chk("reset_moving", int'(moving), 0);
    endtask

    initial begin
        int y;
        int ny;
        int cur;
        int up_exp[5];

        reset = 1'b1; enable = 1'b1; mode_auto = 1'b0;
        up = 1'b0; down = 1'b0; ball_y = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state and idle stability
        chk("rst_y", int'(racket_y), 200);
        chk("rst_moving", int'(moving), 0);
        chk("rst_at_top", int'(at_top), 0);
        chk("rst_at_bottom", int'(at_bottom), 0);
        for (int i = 0; i < 5; i++) run_tick(200, 0, "idle");

        // Hold up: steps 1,1,2,2,3
        up_exp = '{199, 198, 196, 194, 191};
        up = 1'b1;
        for (int i = 0; i < 5; i++) run_tick(up_exp[i], 1, "hold_up");
        up = 1'b0;
        run_tick(191, 0, "release");

        // Hold down to the bottom wall: saturating step, clamp at 400
        do_reset();
        down = 1'b1;
        y = 200;
        for (int k = 0; k < 120; k++) begin
            cur = 1 + k / 2;
            if (cur > 4) cur = 4;
            ny = (y + cur > 400) ? 400 : y + cur;
            run_tick(ny, (ny != y) ? 1 : 0, "hold_down");
            y = ny;
        end
        down = 1'b0;
        chk("bottom_final_y", int'(racket_y), 400);
        chk("bottom_flag", int'(at_bottom), 1);

        // Reversal restarts at STEP_MIN; both buttons hold
        do_reset();
        up = 1'b1;
        run_tick(199, 1, "rev_up1");
        run_tick(198, 1, "rev_up2");
        run_tick(196, 1, "rev_up3");
        up = 1'b0; down = 1'b1;
        run_tick(197, 1, "reversal");
        up = 1'b1;
        run_tick(197, 0, "both_btn1");
        run_tick(197, 0, "both_btn2");
        up = 1'b0; down = 1'b0;

        // Auto mode tracks the ball upward, stops inside the deadzone
        do_reset();
        mode_auto = 1'b1;
        ball_y = 10'd100;
        y = 200;
        while (y + 40 - 100 > 4) begin
            y = y - 2;
            run_tick(y, 1, "auto_up");
        end
        run_tick(64, 0, "auto_settled");

        do_reset();
        ball_y = 10'd242;
        for (int i = 0; i < 3; i++) run_tick(200, 0, "auto_dead");
        ball_y = 10'd300;
        run_tick(202, 1, "auto_down");
        mode_auto = 1'b0;
        ball_y = '0;

        // Frozen while disabled; reset mid-hold restarts acceleration
        do_reset();
        enable = 1'b0; up = 1'b1;
        for (int i = 0; i < 3; i++) run_tick(200, 0, "frozen");
        enable = 1'b1;
        run_tick(199, 1, "en_up1");
        run_tick(198, 1, "en_up2");
        do_reset();
        run_tick(199, 1, "post_rst1");
        run_tick(198, 1, "post_rst2");
        run_tick(196, 1, "post_rst3");
        up = 1'b0;

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) chk("drain", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
